// File: rtl/pipe_pkg.sv
// Shared definitions for the five-stage MIPS pipeline: control bundle layout,
// PCSrc encodings and the all-zero NOP control word.
package pipe_pkg;

    localparam int CTRL_W = 18;

    // Bit positions inside the packed control bundle; bit 17 is reserved.
    localparam int LUOP_BIT     = 0;
    localparam int EXTOP_BIT    = 1;
    localparam int ALUSRC2_BIT  = 2;
    localparam int ALUSRC1_BIT  = 3;
    localparam int MEMTOREG_LSB = 4;
    localparam int MEMTOREG_MSB = 5;
    localparam int EXANO_BIT    = 6;
    localparam int EXWRITE_BIT  = 7;
    localparam int MEMWRITE_BIT = 8;
    localparam int BYTEREAD_BIT = 9;
    localparam int MEMREAD_BIT  = 10;
    localparam int REGDST_LSB   = 11;
    localparam int REGDST_MSB   = 12;
    localparam int REGWRITE_BIT = 13;
    localparam int BRANCH_BIT   = 14;
    localparam int PCSRC_LSB    = 15;
    localparam int PCSRC_MSB    = 16;

    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_JR     = 2'b11;

    localparam logic [CTRL_W-1:0] NOP_CTRL = '0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use compare between the load sitting in EX and the
// instruction being decoded in ID.
module hazard_detect (
    input  logic       exValid,
    input  logic       exMemRead,
    input  logic       exByteRead,
    input  logic [4:0] exRt,
    input  logic       idValid,
    input  logic [1:0] idPcSrc,
    input  logic       idAluSrc1,
    input  logic       idAluSrc2,
    input  logic       idMemWrite,
    input  logic       idBranch,
    input  logic       idExWrite,
    input  logic [4:0] idRs,
    input  logic [4:0] idRt,
    output logic       hazard
);
    import pipe_pkg::*;

    logic exLoad;
    logic useRs;
    logic useRt;

    // A load into $0 never produces a value, so it cannot cause a stall.
    assign exLoad = exValid & (exMemRead | exByteRead) & (exRt != 5'd0);
    assign useRs  = ~idAluSrc1 & (idPcSrc != PCSRC_JUMP);
    assign useRt  = ~idAluSrc2 | idMemWrite | idBranch | idExWrite;

    assign hazard = exLoad & idValid &
                    ((useRs & (idRs == exRt)) | (useRt & (idRt == exRt)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and bubble insertion.
// Define HAZARD_STAT_EN to build the saturating stall/flush counters.
module id_ex_stage #(
    parameter int CTRL_W = 18,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [31:0]       id_pc4,
    input  logic [31:0]       id_rs_data,
    input  logic [31:0]       id_rt_data,
    input  logic [31:0]       id_imm,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [4:0]        id_shamt,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [31:0]       ex_pc4,
    output logic [31:0]       ex_rs_data,
    output logic [31:0]       ex_rt_data,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [4:0]        ex_shamt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    import pipe_pkg::*;

    logic hazard;

    hazard_detect hazardUnit (
        .exValid   (ex_valid),
        .exMemRead (ex_ctrl[MEMREAD_BIT]),
        .exByteRead(ex_ctrl[BYTEREAD_BIT]),
        .exRt      (ex_rt),
        .idValid   (id_valid),
        .idPcSrc   (id_ctrl[PCSRC_MSB:PCSRC_LSB]),
        .idAluSrc1 (id_ctrl[ALUSRC1_BIT]),
        .idAluSrc2 (id_ctrl[ALUSRC2_BIT]),
        .idMemWrite(id_ctrl[MEMWRITE_BIT]),
        .idBranch  (id_ctrl[BRANCH_BIT]),
        .idExWrite (id_ctrl[EXWRITE_BIT]),
        .idRs      (id_rs),
        .idRt      (id_rt),
        .hazard    (hazard)
    );

    // A flush already redirects fetch, so the stall would be redundant.
    assign stall_o = hazard & ~flush_i;

    // ID -> EX boundary: control
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= CTRL_W'(NOP_CTRL);
        end else if (flush_i || hazard) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= CTRL_W'(NOP_CTRL);
        end else begin
            ex_valid <= id_valid;
            ex_ctrl  <= id_ctrl;
        end
    end

    // ID -> EX boundary: data and fields (don't-care under a bubble)
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_pc4     <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            ex_shamt   <= '0;
        end else begin
            ex_pc4     <= id_pc4;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd      <= id_rd;
            ex_shamt   <= id_shamt;
        end
    end

`ifdef HAZARD_STAT_EN
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
        return (value == '1) ? value : value + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_o) begin
                stall_cnt <= satInc(stall_cnt);
            end
            if (flush_i && id_valid) begin
                flush_cnt <= satInc(flush_cnt);
            end
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts each edge's EX
// contents, stall and counters; results are queued and compared after the edge.
module tb_id_ex_stage;
    import pipe_pkg::*;

    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [CTRL_W-1:0] id_ctrl;
    logic [31:0]       id_pc4, id_rs_data, id_rt_data, id_imm;
    logic [4:0]        id_rs, id_rt, id_rd, id_shamt;
    logic              flush_i;
    logic              stall_o;
    logic              ex_valid;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [31:0]       ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]        ex_rs, ex_rt, ex_rd, ex_shamt;
    logic [CW-1:0]     stall_cnt, flush_cnt;

    id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_shamt(id_shamt), .flush_i(flush_i), .stall_o(stall_o),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             tag;
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic              chkData;
        logic [31:0]       pc4, rsData, rtData, imm;
        logic [4:0]        rs, rt, rd, shamt;
        logic [CW-1:0]     sc, fc;
    } expT;

    expT expQ[$];

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic              mValid = 1'b0;
    logic [CTRL_W-1:0] mCtrl = '0;
    logic [4:0]        mRt = '0;
    logic [CW-1:0]     mSc = '0, mFc = '0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CTRL_W-1:0] mkCtrl(input logic [1:0] pcSrc, input logic regWrite,
                                                 input logic memRead, input logic byteRead,
                                                 input logic aluSrc1, input logic aluSrc2,
                                                 input logic luOp);
        logic [CTRL_W-1:0] c;
        c = '0;
        c[PCSRC_MSB:PCSRC_LSB] = pcSrc;
        c[REGWRITE_BIT] = regWrite;
        c[MEMREAD_BIT]  = memRead;
        c[BYTEREAD_BIT] = byteRead;
        c[ALUSRC1_BIT]  = aluSrc1;
        c[ALUSRC2_BIT]  = aluSrc2;
        c[LUOP_BIT]     = luOp;
        if (memRead || byteRead) begin
            c[MEMTOREG_MSB:MEMTOREG_LSB] = 2'b01;
            c[EXTOP_BIT] = 1'b1;
        end
        return c;
    endfunction

    function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // One ID cycle: drive, check stall, predict, clock, compare.
    task automatic step(input string tag, input logic rst, input logic v,
                        input logic [CTRL_W-1:0] c, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] rsD, input logic [31:0] rtD, input logic fl);
        expT e;
        logic exLoad, useRs, useRt, haz, expStall;
        @(negedge clk);
        reset = rst; id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsD; id_rt_data = rtD; flush_i = fl;
        id_pc4 = $urandom; id_imm = $urandom; id_shamt = 5'($urandom_range(0, 31));
        #1;
        exLoad = mValid && (mCtrl[MEMREAD_BIT] || mCtrl[BYTEREAD_BIT]) && (mRt != 5'd0);
        useRs = !c[ALUSRC1_BIT] && (c[PCSRC_MSB:PCSRC_LSB] != 2'b10);
        useRt = !c[ALUSRC2_BIT] || c[MEMWRITE_BIT] || c[BRANCH_BIT] || c[EXWRITE_BIT];
        haz = exLoad && v && ((useRs && rs == mRt) || (useRt && rt == mRt));
        expStall = haz && !fl;
        if (!rst) checkVal({tag, ".stall"}, 32'(stall_o), 32'(expStall));

        e.tag = tag;
        if (rst) begin
            mValid = 1'b0; mCtrl = '0; mRt = '0; mSc = '0; mFc = '0;
            e.chkData = 1'b1;
            e.pc4 = '0; e.rsData = '0; e.rtData = '0; e.imm = '0;
            e.rs = '0; e.rt = '0; e.rd = '0; e.shamt = '0;
        end else begin
            if (expStall) mSc = sat(mSc);
            if (fl && v) mFc = sat(mFc);
            e.chkData = !(fl || haz);
            e.pc4 = id_pc4; e.rsData = rsD; e.rtData = rtD; e.imm = id_imm;
            e.rs = rs; e.rt = rt; e.rd = rd; e.shamt = id_shamt;
            if (fl || haz) begin
                mValid = 1'b0; mCtrl = '0;
            end else begin
                mValid = v; mCtrl = c;
            end
            mRt = rt;
        end
        e.valid = mValid;
        e.ctrl = mCtrl;
`ifdef HAZARD_STAT_EN
        e.sc = mSc; e.fc = mFc;
`else
        e.sc = '0; e.fc = '0;
`endif
        expQ.push_back(e);

        @(posedge clk);
        #1;
        e = expQ.pop_front();
        checkVal({e.tag, ".ex_valid"}, 32'(ex_valid), 32'(e.valid));
        checkVal({e.tag, ".ex_ctrl"}, 32'(ex_ctrl), 32'(e.ctrl));
        checkVal({e.tag, ".stall_cnt"}, 32'(stall_cnt), 32'(e.sc));
        checkVal({e.tag, ".flush_cnt"}, 32'(flush_cnt), 32'(e.fc));
        if (e.chkData) begin
            checkVal({e.tag, ".ex_pc4"}, ex_pc4, e.pc4);
            checkVal({e.tag, ".ex_rs_data"}, ex_rs_data, e.rsData);
            checkVal({e.tag, ".ex_rt_data"}, ex_rt_data, e.rtData);
            checkVal({e.tag, ".ex_imm"}, ex_imm, e.imm);
            checkVal({e.tag, ".ex_fields"}, {12'd0, ex_rs, ex_rt, ex_rd, ex_shamt},
                     {12'd0, e.rs, e.rt, e.rd, e.shamt});
        end
    endtask

    logic [CTRL_W-1:0] cAddu, cLw, cLb, cSll, cLui, cJump;

    initial begin
        cAddu = mkCtrl(PCSRC_SEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cLw   = mkCtrl(PCSRC_SEQ, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cLb   = mkCtrl(PCSRC_SEQ, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cSll  = mkCtrl(PCSRC_SEQ, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cLui  = mkCtrl(PCSRC_SEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cJump = mkCtrl(PCSRC_JUMP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        step("rst0", 1'b1, 1'b1, CTRL_W'($urandom), 5'd3, 5'd4, 5'd5, $urandom, $urandom, 1'b0);
        step("rst1", 1'b1, 1'b1, CTRL_W'($urandom), 5'd7, 5'd8, 5'd9, $urandom, $urandom, 1'b1);
        checkVal("rst.stall", 32'(stall_o), 32'(1'b0));

        step("addu", 1'b0, 1'b1, cAddu, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 1'b0);

        step("lw4", 1'b0, 1'b1, cLw, 5'd1, 5'd4, 5'd0, 32'd100, 32'd0, 1'b0);
        step("use_stall", 1'b0, 1'b1, cAddu, 5'd4, 5'd2, 5'd5, 32'd11, 32'd22, 1'b0);
        step("use_load", 1'b0, 1'b1, cAddu, 5'd4, 5'd2, 5'd5, 32'd11, 32'd22, 1'b0);

        step("lw0", 1'b0, 1'b1, cLw, 5'd1, 5'd0, 5'd0, 32'd1, 32'd0, 1'b0);
        step("use0", 1'b0, 1'b1, cAddu, 5'd0, 5'd2, 5'd5, 32'd3, 32'd4, 1'b0);

        step("lw4b", 1'b0, 1'b1, cLw, 5'd1, 5'd4, 5'd0, 32'd1, 32'd0, 1'b0);
        step("sll_stall", 1'b0, 1'b1, cSll, 5'd0, 5'd4, 5'd6, 32'd0, 32'd9, 1'b0);
        step("sll_load", 1'b0, 1'b1, cSll, 5'd0, 5'd4, 5'd6, 32'd0, 32'd9, 1'b0);

        step("lw4c", 1'b0, 1'b1, cLw, 5'd1, 5'd4, 5'd0, 32'd1, 32'd0, 1'b0);
        step("lui", 1'b0, 1'b1, cLui, 5'd0, 5'd4, 5'd0, 32'd0, 32'd0, 1'b0);

        step("lb7", 1'b0, 1'b1, cLb, 5'd2, 5'd7, 5'd0, 32'd1, 32'd0, 1'b0);
        step("lb_use", 1'b0, 1'b1, cAddu, 5'd3, 5'd7, 5'd8, 32'd5, 32'd6, 1'b0);
        step("lb_load", 1'b0, 1'b1, cAddu, 5'd3, 5'd7, 5'd8, 32'd5, 32'd6, 1'b0);

        step("lw4d", 1'b0, 1'b1, cLw, 5'd1, 5'd4, 5'd0, 32'd1, 32'd0, 1'b0);
        step("jump_rs", 1'b0, 1'b1, cJump, 5'd4, 5'd4, 5'd0, 32'd0, 32'd0, 1'b0);

        step("lw4e", 1'b0, 1'b1, cLw, 5'd1, 5'd4, 5'd0, 32'd1, 32'd0, 1'b0);
        step("flush_haz", 1'b0, 1'b1, cAddu, 5'd4, 5'd2, 5'd5, 32'd1, 32'd2, 1'b1);
        step("after_flush", 1'b0, 1'b1, cAddu, 5'd4, 5'd2, 5'd5, 32'd1, 32'd2, 1'b0);

        step("invalid", 1'b0, 1'b0, cLw, 5'd1, 5'd9, 5'd0, 32'd1, 32'd0, 1'b0);
        step("invalid_next", 1'b0, 1'b1, cAddu, 5'd9, 5'd9, 5'd1, 32'd1, 32'd2, 1'b0);
        step("flush_novalid", 1'b0, 1'b0, cAddu, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 1'b1);

        for (int i = 0; i < 20; i++) begin
            step("sat_lw", 1'b0, 1'b1, cLw, 5'd1, 5'd4, 5'd0, 32'(i), 32'd0, 1'b0);
            step("sat_stall", 1'b0, 1'b1, cAddu, 5'd4, 5'd2, 5'd5, 32'(i), 32'd1, 1'b0);
            step("sat_load", 1'b0, 1'b1, cAddu, 5'd4, 5'd2, 5'd5, 32'(i), 32'd1, 1'b0);
        end

        step("mid_lw", 1'b0, 1'b1, cLw, 5'd1, 5'd4, 5'd0, 32'd1, 32'd0, 1'b0);
        step("mid_rst", 1'b1, 1'b1, cAddu, 5'd4, 5'd2, 5'd5, 32'd1, 32'd2, 1'b0);
        step("post_rst", 1'b0, 1'b1, cAddu, 5'd4, 5'd2, 5'd5, 32'd3, 32'd4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
